// File: rtl/mem_req_arbiter.sv
// Arbitrates icache/dcache memory requests onto one proc2mem port and routes returning load data by tag.
// Latency: grant, accept and data routing are combinational; table, count and error update at the next edge.
// Backpressure: a zero transaction tag rejects the grant, and the requester re-presents on the next cycle.
module mem_req_arbiter #(
    // Matches the codebase's NUM_MEM_TAGS constant.
    parameter int NUM_TAGS     = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        icache_req_valid,
    input  logic [31:0] icache_req_addr,
    output logic        icache_req_accepted,

    input  logic        dcache_req_valid,
    input  logic [1:0]  dcache_req_cmd,
    input  logic [31:0] dcache_req_addr,
    input  logic [63:0] dcache_req_data,
    output logic        dcache_req_accepted,

    output logic [3:0]  granted_tag,
    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,

    input  logic [3:0]  mem2proc_transaction_tag,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_data_tag,

    output logic        icache_data_valid,
    output logic [63:0] icache_data,
    output logic [3:0]  icache_data_tag,
    output logic        dcache_data_valid,
    output logic [63:0] dcache_data,
    output logic [3:0]  dcache_data_tag,

    output logic [4:0]  outstanding_count,
    output logic        error
);

    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;
    localparam int         SW        = $clog2(STARVE_LIMIT + 1);

    // Indexed directly by the 4-bit tag; entry 0 and entries above NUM_TAGS are never set.
    logic [15:0]   tbl_valid;
    logic [15:0]   tbl_owner;     // 0 = icache, 1 = dcache
    logic [SW-1:0] starve_cnt;

    logic        starved;
    logic        grant_ic;
    logic        grant_dc;
    logic        mem_ok;
    logic [15:0] live_valid;
    logic        ret_in_range;
    logic        ret_hit;
    logic        ret_miss;
    logic        ret_owner;
    logic        load_acc;
    logic        load_in_range;
    logic        load_set;
    logic        load_dup;
    logic        load_bad;
    logic        load_owner;
    logic        cnt_inc;
    logic        cnt_dec;

    // Priority decision: dcache by default, icache once it has been denied long enough.
    always_comb begin
        starved  = (starve_cnt == SW'(STARVE_LIMIT));
        grant_ic = icache_req_valid && (!dcache_req_valid || starved);
        grant_dc = dcache_req_valid && !grant_ic;
        mem_ok   = (mem2proc_transaction_tag != 4'd0);
        icache_req_accepted = grant_ic && mem_ok;
        dcache_req_accepted = grant_dc && mem_ok;
        granted_tag = (icache_req_accepted || dcache_req_accepted) ? mem2proc_transaction_tag : 4'd0;
    end

    // Drive the memory port from whichever requester holds the grant.
    always_comb begin
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = 32'd0;
        proc2mem_data    = 64'd0;
        if (grant_ic) begin
            proc2mem_command = MEM_LOAD;
            proc2mem_addr    = icache_req_addr;
        end else if (grant_dc) begin
            proc2mem_command = dcache_req_cmd;
            proc2mem_addr    = dcache_req_addr;
            proc2mem_data    = dcache_req_data;
        end
    end

    // Table lookups for returns and new loads; the table reads as empty while in reset.
    always_comb begin
        live_valid    = reset ? 16'd0 : tbl_valid;
        ret_in_range  = (mem2proc_data_tag != 4'd0) && (32'(mem2proc_data_tag) <= NUM_TAGS);
        ret_hit       = ret_in_range && live_valid[mem2proc_data_tag];
        ret_owner     = tbl_owner[mem2proc_data_tag];
        ret_miss      = (mem2proc_data_tag != 4'd0) && !ret_hit;
        load_acc      = icache_req_accepted ||
                        (dcache_req_accepted && dcache_req_cmd == MEM_LOAD);
        load_owner    = dcache_req_accepted;
        load_in_range = (32'(mem2proc_transaction_tag) <= NUM_TAGS);
        load_set      = load_acc && load_in_range;
        load_bad      = load_acc && !load_in_range;
        // A same-cycle return on the same tag frees the entry, so reusing it is legal.
        load_dup      = load_set && live_valid[mem2proc_transaction_tag] &&
                        !(ret_hit && mem2proc_data_tag == mem2proc_transaction_tag);
        // An overwrite keeps the entry count unchanged.
        cnt_inc       = load_set && !load_dup;
        cnt_dec       = ret_hit;
    end

    // Route returning load data to the recorded owner; idle outputs are all zero.
    always_comb begin
        icache_data_valid = ret_hit && !ret_owner;
        dcache_data_valid = ret_hit && ret_owner;
        icache_data       = icache_data_valid ? mem2proc_data     : 64'd0;
        icache_data_tag   = icache_data_valid ? mem2proc_data_tag : 4'd0;
        dcache_data       = dcache_data_valid ? mem2proc_data     : 64'd0;
        dcache_data_tag   = dcache_data_valid ? mem2proc_data_tag : 4'd0;
    end

    // State update: starvation counter, ownership table (set wins over clear), count and sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            tbl_valid         <= 16'd0;
            tbl_owner         <= 16'd0;
            starve_cnt        <= '0;
            outstanding_count <= 5'd0;
            error             <= 1'b0;
        end else begin
            if (!icache_req_valid || icache_req_accepted)
                starve_cnt <= '0;
            else if (!starved)
                starve_cnt <= starve_cnt + SW'(1);

            if (ret_hit)
                tbl_valid[mem2proc_data_tag] <= 1'b0;
            if (load_set) begin
                tbl_valid[mem2proc_transaction_tag] <= 1'b1;
                tbl_owner[mem2proc_transaction_tag] <= load_owner;
            end

            outstanding_count <= outstanding_count + {4'd0, cnt_inc} - {4'd0, cnt_dec};

            if (ret_miss || load_dup || load_bad)
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: per-cycle expectations queued by the driver, checked by a monitor.
// Inputs change 1 time unit after posedge; the monitor samples on negedge.
// Expected values are hand-derived per cycle.
module tb_mem_req_arbiter;

    localparam logic [1:0]  NONE  = 2'd0;
    localparam logic [1:0]  LOAD  = 2'd1;
    localparam logic [1:0]  STORE = 2'd2;
    localparam logic [31:0] IA = 32'h0000_1000;
    localparam logic [31:0] DA = 32'h0000_2040;
    localparam logic [63:0] DD = 64'hA5A5_0000_0000_5A5A;
    localparam logic [63:0] D5 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] D3 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] X1 = 64'h1357_9BDF_0246_8ACE;
    localparam logic [63:0] X2 = 64'hFEDC_BA98_7654_3210;

    logic        clock = 1'b0;
    logic        reset;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_accepted;
    logic        dcache_req_valid;
    logic [1:0]  dcache_req_cmd;
    logic [31:0] dcache_req_addr;
    logic [63:0] dcache_req_data;
    logic        dcache_req_accepted;
    logic [3:0]  granted_tag;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_transaction_tag;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_data_tag;
    logic        icache_data_valid;
    logic [63:0] icache_data;
    logic [3:0]  icache_data_tag;
    logic        dcache_data_valid;
    logic [63:0] dcache_data;
    logic [3:0]  dcache_data_tag;
    logic [4:0]  outstanding_count;
    logic        error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ic_acc;
        logic        dc_acc;
        logic [3:0]  gtag;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic        ic_dv;
        logic [63:0] ic_d;
        logic [3:0]  ic_t;
        logic        dc_dv;
        logic [63:0] dc_d;
        logic [3:0]  dc_t;
        logic [4:0]  cnt;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    mem_req_arbiter #(.NUM_TAGS(15), .STARVE_LIMIT(4)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .icache_req_valid         (icache_req_valid),
        .icache_req_addr          (icache_req_addr),
        .icache_req_accepted      (icache_req_accepted),
        .dcache_req_valid         (dcache_req_valid),
        .dcache_req_cmd           (dcache_req_cmd),
        .dcache_req_addr          (dcache_req_addr),
        .dcache_req_data          (dcache_req_data),
        .dcache_req_accepted      (dcache_req_accepted),
        .granted_tag              (granted_tag),
        .proc2mem_command         (proc2mem_command),
        .proc2mem_addr            (proc2mem_addr),
        .proc2mem_data            (proc2mem_data),
        .mem2proc_transaction_tag (mem2proc_transaction_tag),
        .mem2proc_data            (mem2proc_data),
        .mem2proc_data_tag        (mem2proc_data_tag),
        .icache_data_valid        (icache_data_valid),
        .icache_data              (icache_data),
        .icache_data_tag          (icache_data_tag),
        .dcache_data_valid        (dcache_data_valid),
        .dcache_data              (dcache_data),
        .dcache_data_tag          (dcache_data_tag),
        .outstanding_count        (outstanding_count),
        .error                    (error)
    );

    always #5 clock = ~clock;

    function automatic exp_t idle(input logic [4:0] cnt, input logic err);
        exp_t e;
        e = '{ic_acc: 1'b0, dc_acc: 1'b0, gtag: 4'd0, cmd: NONE, addr: 32'd0, data: 64'd0,
              ic_dv: 1'b0, ic_d: 64'd0, ic_t: 4'd0, dc_dv: 1'b0, dc_d: 64'd0, dc_t: 4'd0,
              cnt: cnt, err: err};
        return e;
    endfunction

    // dcache holds the port; a zero memory tag means it is not accepted.
    function automatic exp_t g_dc(input exp_t b, input logic [1:0] cmd, input logic [3:0] tag);
        exp_t e;
        e = b;
        e.cmd = cmd; e.addr = DA; e.data = DD;
        e.dc_acc = (tag != 4'd0); e.gtag = tag;
        return e;
    endfunction

    function automatic exp_t g_ic(input exp_t b, input logic [3:0] tag);
        exp_t e;
        e = b;
        e.cmd = LOAD; e.addr = IA; e.data = 64'd0;
        e.ic_acc = (tag != 4'd0); e.gtag = tag;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic cyc(input logic rst, input logic iv, input logic dv, input logic [1:0] dcmd,
                       input logic [3:0] mtag, input logic [3:0] mdtag, input logic [63:0] mdata,
                       input exp_t e);
        @(posedge clock);
        #1;
        reset                    = rst;
        icache_req_valid         = iv;
        dcache_req_valid         = dv;
        dcache_req_cmd           = dcmd;
        mem2proc_transaction_tag = mtag;
        mem2proc_data_tag        = mdtag;
        mem2proc_data            = mdata;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle with a queued expectation, compare the full output set.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("icache_req_accepted", 64'(icache_req_accepted), 64'(e.ic_acc));
            chk("dcache_req_accepted", 64'(dcache_req_accepted), 64'(e.dc_acc));
            chk("granted_tag",         64'(granted_tag),         64'(e.gtag));
            chk("proc2mem_command",    64'(proc2mem_command),    64'(e.cmd));
            chk("proc2mem_addr",       64'(proc2mem_addr),       64'(e.addr));
            chk("proc2mem_data",       proc2mem_data,            e.data);
            chk("icache_data_valid",   64'(icache_data_valid),   64'(e.ic_dv));
            chk("icache_data",         icache_data,              e.ic_d);
            chk("icache_data_tag",     64'(icache_data_tag),     64'(e.ic_t));
            chk("dcache_data_valid",   64'(dcache_data_valid),   64'(e.dc_dv));
            chk("dcache_data",         dcache_data,              e.dc_d);
            chk("dcache_data_tag",     64'(dcache_data_tag),     64'(e.dc_t));
            chk("outstanding_count",   64'(outstanding_count),   64'(e.cnt));
            chk("error",               64'(error),               64'(e.err));
        end
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        icache_req_valid = 1'b0; icache_req_addr = IA;
        dcache_req_valid = 1'b0; dcache_req_cmd = NONE;
        dcache_req_addr = DA;    dcache_req_data = DD;
        mem2proc_transaction_tag = 4'd0; mem2proc_data = 64'd0; mem2proc_data_tag = 4'd0;

        // Reset cycle with a return on tag 5: dropped, no error.
        cyc(1, 0, 0, NONE, 0, 5, D5, idle(0, 0));
        // Both request, mem tag 3: dcache wins.
        cyc(0, 1, 1, LOAD, 3, 0, 0, g_dc(idle(0, 0), LOAD, 3));
        cyc(0, 0, 0, NONE, 0, 0, 0, idle(1, 0));
        // icache load on tag 5, then its return.
        cyc(0, 1, 0, NONE, 5, 0, 0, g_ic(idle(1, 0), 5));
        e = idle(2, 0); e.ic_dv = 1'b1; e.ic_d = D5; e.ic_t = 4'd5;
        cyc(0, 0, 0, NONE, 0, 5, D5, e);
        // Return of the dcache load on tag 3.
        e = idle(1, 0); e.dc_dv = 1'b1; e.dc_d = D3; e.dc_t = 4'd3;
        cyc(0, 0, 0, NONE, 0, 3, D3, e);
        // Rejected dcache request (tag 0): no acceptance, no state change.
        cyc(0, 0, 1, LOAD, 0, 0, 0, g_dc(idle(0, 0), LOAD, 0));
        // No requester but a nonzero memory tag: nothing granted.
        cyc(0, 0, 0, NONE, 4, 0, 0, idle(0, 0));
        // Starvation: dcache stores win four cycles, then icache load wins on tag 7.
        for (int i = 1; i <= 4; i++)
            cyc(0, 1, 1, STORE, 4'(i), 0, 0, g_dc(idle(0, 0), STORE, 4'(i)));
        cyc(0, 1, 1, STORE, 7, 0, 0, g_ic(idle(0, 0), 7));
        cyc(0, 1, 1, STORE, 6, 0, 0, g_dc(idle(1, 0), STORE, 6));
        cyc(0, 0, 0, NONE, 0, 0, 0, idle(1, 0));
        // Tag 7 returns to icache while dcache load is accepted on tag 7.
        e = g_dc(idle(1, 0), LOAD, 7); e.ic_dv = 1'b1; e.ic_d = X1; e.ic_t = 4'd7;
        cyc(0, 0, 1, LOAD, 7, 7, X1, e);
        cyc(0, 0, 0, NONE, 0, 0, 0, idle(1, 0));
        e = idle(1, 0); e.dc_dv = 1'b1; e.dc_d = X2; e.dc_t = 4'd7;
        cyc(0, 0, 0, NONE, 0, 7, X2, e);
        // Store on tag 2, then a return on tag 2: error next cycle.
        cyc(0, 0, 1, STORE, 2, 0, 0, g_dc(idle(0, 0), STORE, 2));
        cyc(0, 0, 0, NONE, 0, 2, X1, idle(0, 0));
        cyc(0, 0, 0, NONE, 0, 0, 0, idle(0, 1));
        // Reset clears the error, then three loads go in flight.
        cyc(1, 0, 0, NONE, 0, 0, 0, idle(0, 1));
        cyc(0, 0, 1, LOAD, 1, 0, 0, g_dc(idle(0, 0), LOAD, 1));
        cyc(0, 0, 1, LOAD, 2, 0, 0, g_dc(idle(1, 0), LOAD, 2));
        cyc(0, 1, 0, NONE, 4, 0, 0, g_ic(idle(2, 0), 4));
        cyc(0, 0, 0, NONE, 0, 0, 0, idle(3, 0));
        // Reset with loads in flight; a return during reset is dropped.
        cyc(1, 0, 0, NONE, 0, 1, X2, idle(3, 0));
        cyc(0, 0, 0, NONE, 0, 0, 0, idle(0, 0));
        // Stale tag 2 returns after reset: error.
        cyc(0, 0, 0, NONE, 0, 2, X1, idle(0, 0));
        cyc(0, 0, 0, NONE, 0, 0, 0, idle(0, 1));
        // Duplicate load on tag 9: error, entry reowned by icache, count stays 1.
        cyc(1, 0, 0, NONE, 0, 0, 0, idle(0, 1));
        cyc(0, 0, 1, LOAD, 9, 0, 0, g_dc(idle(0, 0), LOAD, 9));
        cyc(0, 1, 0, NONE, 9, 0, 0, g_ic(idle(1, 0), 9));
        e = idle(1, 1); e.ic_dv = 1'b1; e.ic_d = D5; e.ic_t = 4'd9;
        cyc(0, 0, 0, NONE, 0, 9, D5, e);
        cyc(0, 0, 0, NONE, 0, 0, 0, idle(0, 1));

        // Drain the scoreboard within a bounded number of cycles.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++)
            @(posedge clock);
        @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
